div_seq: RTL and testbench

//  Iterative radix-2 restoring divider; the sequential counterpart of the combinational mul unit.

---
 rtl/div_seq_pkg.sv | 12 +
 rtl/div_step.sv | 25 ++
 rtl/div_seq.sv | 122 ++++++++++++
 tb/tb_div_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package div_seq_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH+1:0] w_trial;

  // rem < divisor always holds, so the shifted value fits in WIDTH+1 bits;
  // one extra bit carries the borrow that decides keep vs. restore.
  assign w_shifted = {i_rem, i_quo[WIDTH-1]};
  assign w_trial   = {1'b0, w_shifted} - {2'b00, i_divisor};

  always_comb begin
    o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH+1]};
    o_rem = w_trial[WIDTH+1] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider for MIPS DIV/DIVU: start/busy/done handshake, one op in flight.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_q,
  output logic [WIDTH-1:0] data_r,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz_pend;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // Unsigned WIDTH-bit magnitude: the most negative value maps onto itself.
  assign w_abs_a = (sign && data_a[WIDTH-1]) ? -data_a : data_a;
  assign w_abs_b = (sign && data_b[WIDTH-1]) ? -data_b : data_b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_div),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz_pend <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_q       <= '0;
      r_r       <= '0;
      r_dz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= CW'(WIDTH - 1);
            r_rem   <= '0;
            r_div   <= w_abs_b;
            r_neg_q <= sign & (data_a[WIDTH-1] ^ data_b[WIDTH-1]);
            r_neg_r <= sign & data_a[WIDTH-1];
            if (data_b == '0) begin
              // quotient register parks the raw dividend; it becomes the remainder
              r_dz_pend <= 1'b1;
              r_quo     <= data_a;
              r_state   <= ST_FIX;
            end else begin
              r_dz_pend <= 1'b0;
              r_quo     <= w_abs_a;
              r_state   <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (r_dz_pend) begin
            r_q  <= '1;
            r_r  <= r_quo;
            r_dz <= 1'b1;
          end else begin
            r_q  <= r_neg_q ? -r_quo : r_quo;
            r_r  <= r_neg_r ? -r_rem : r_rem;
            r_dz <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign data_q   = r_q;
  assign data_r   = r_r;
  assign div_zero = r_dz;

endmodule

// File: tb/tb_div_seq.sv
// Randomized self-checking bench for div_seq against an arithmetic reference model.
module tb_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sign;
  logic [W-1:0] data_a, data_b, data_q, data_r;
  logic         busy, done, div_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_a   (data_a),
    .data_b   (data_b),
    .sign     (sign),
    .busy     (busy),
    .done     (done),
    .data_q   (data_q),
    .data_r   (data_r),
    .div_zero (div_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic truncates toward zero with remainder
  // taking the dividend's sign, and absorbs the MIN / -1 overflow.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb, lq, lr;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
    end
  endfunction

  // Waits for done (bounded); returns edges counted, starting at 1 for the first edge.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
    logic [W-1:0] eq, er;
    int n;
    ref_div(a, b, s, eq, er);
    @(negedge clk);
    data_a = a; data_b = b; sign = s; start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    data_a = $urandom; data_b = $urandom; sign = 1'($urandom);
    chk({tag, " busy"}, 64'(busy), 64'd1);
    wait_done(1, n);
    chk({tag, " latency"}, 64'(n), 64'((b == 0) ? 2 : W + 2));
    chk({tag, " q"}, 64'(data_q), 64'(eq));
    chk({tag, " r"}, 64'(data_r), 64'(er));
    chk({tag, " dz"}, 64'(div_zero), 64'(b == 0));
    @(posedge clk);
    #1;
    chk({tag, " done width"}, 64'(done), 64'd0);
    chk({tag, " q hold"}, 64'(data_q), 64'(eq));
  endtask

  initial begin
    logic [W-1:0] a1, b1, a2, b2, eq1, er1, eq2, er2, ra, rb;
    logic s1, s2, rs;
    int n, pulses;

    rst = 1'b1; start = 1'b0; sign = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset q", 64'(data_q), 64'd0);
    chk("reset r", 64'(data_r), 64'd0);
    chk("reset dz", 64'(div_zero), 64'd0);
    rst = 1'b0;

    run_op("divu ffff0001/3", 32'hFFFF0001, 32'd3, 1'b0);
    run_op("div -65535/7", 32'hFFFF0001, 32'd7, 1'b1);
    run_op("div min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1);
    run_op("div -7/2", 32'hFFFFFFF9, 32'd2, 1'b1);
    run_op("div 7/-2", 32'd7, 32'hFFFFFFFE, 1'b1);
    run_op("divu min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op("divz u", 32'h12345678, 32'd0, 1'b0);
    run_op("divz s", 32'h12345678, 32'd0, 1'b1);
    run_op("divu 0/5", 32'd0, 32'd5, 1'b0);
    run_op("div min/1", 32'h80000000, 32'd1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(7))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(15));
        2:       rb = 32'hFFFFFFFF;
        3:       rb = $urandom >> $urandom_range(31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(7) == 0) ra = 32'h80000000;
      rs = 1'($urandom);
      run_op("rand", ra, rb, rs);
    end

    // start held high with changing operands; only the first op and the one
    // presented in the done cycle may be accepted
    a1 = $urandom; b1 = $urandom | 32'h1; s1 = 1'($urandom);
    a2 = $urandom; b2 = ($urandom >> 20) | 32'h1; s2 = 1'($urandom);
    ref_div(a1, b1, s1, eq1, er1);
    ref_div(a2, b2, s2, eq2, er2);
    @(negedge clk);
    data_a = a1; data_b = b1; sign = s1; start = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
      data_a = $urandom; data_b = $urandom; sign = 1'($urandom);
    end
    chk("hold latency", 64'(n), 64'(W + 2));
    chk("hold q", 64'(data_q), 64'(eq1));
    chk("hold r", 64'(data_r), 64'(er1));
    data_a = a2; data_b = b2; sign = s2;
    @(posedge clk);
    #1;
    start = 1'b0;
    data_a = $urandom; data_b = $urandom;
    chk("b2b done width", 64'(done), 64'd0);
    chk("b2b busy", 64'(busy), 64'd1);
    chk("b2b old q", 64'(data_q), 64'(eq1));
    wait_done(1, n);
    chk("b2b latency", 64'(n), 64'(W + 2));
    chk("b2b q", 64'(data_q), 64'(eq2));
    chk("b2b r", 64'(data_r), 64'(er2));

    // reset in the middle of CALC
    run_op("pre-reset", 32'hDEADBEEF, 32'd13, 1'b0);
    @(negedge clk);
    data_a = 32'h7654321; data_b = 32'd9; sign = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort q", 64'(data_q), 64'd0);
    chk("abort r", 64'(data_r), 64'd0);
    chk("abort dz", 64'(div_zero), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    chk("abort no done", 64'(pulses), 64'd0);
    run_op("post-reset", 32'hFFFFFF00, 32'd10, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
